// File: rtl/ucode_pkg.sv
// Shared opcodes, instruction field positions, FSM states and word assemblers
// for the MUL-to-microcode expansion path.
package ucode_pkg;

    localparam logic [6:0]  OP_MOV    = 7'b0000000;
    localparam logic [6:0]  OP_ADD    = 7'b0110001;
    localparam logic [6:0]  OP_SUB    = 7'b0110010;
    localparam logic [6:0]  OP_MUL    = 7'b0110011;
    localparam logic [31:0] NOP_INSTR = {5'b11001, 27'b0};

    localparam int OPC_LSB = 25;
    localparam int RD_LSB  = 21;
    localparam int RS1_LSB = 17;
    localparam int RS2_LSB = 13;
    localparam int IMM_LSB = 0;
    localparam int OPC_W   = 7;
    localparam int REG_W   = 4;
    localparam int IMM_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLR,
        ST_MOV,
        ST_ADD
    } state_e;

    function automatic logic [31:0] make_r(input logic [OPC_W-1:0] op,
                                           input logic [REG_W-1:0] rd,
                                           input logic [REG_W-1:0] rs1,
                                           input logic [REG_W-1:0] rs2);
        logic [31:0] w;
        w = '0;
        w[OPC_LSB +: OPC_W] = op;
        w[RD_LSB  +: REG_W] = rd;
        w[RS1_LSB +: REG_W] = rs1;
        w[RS2_LSB +: REG_W] = rs2;
        return w;
    endfunction

    function automatic logic [31:0] make_i(input logic [OPC_W-1:0] op,
                                           input logic [REG_W-1:0] rd,
                                           input logic [IMM_W-1:0] imm);
        logic [31:0] w;
        w = '0;
        w[OPC_LSB +: OPC_W] = op;
        w[RD_LSB  +: REG_W] = rd;
        w[IMM_LSB +: IMM_W] = imm;
        return w;
    endfunction

endpackage

// File: rtl/ucode_uop_gen.sv
// Formats the micro-op word for the current sequencer state.
// Latency: combinational, 0 cycles.
// Backpressure: none; holds as long as state and operands hold.
module ucode_uop_gen
    import ucode_pkg::*;
(
    input  state_e       state,
    input  logic [3:0]   rd,
    input  logic [3:0]   rs1,
    output logic [31:0]  instr
);

    always_comb begin
        instr = NOP_INSTR;
        case (state)
            ST_CLR:  instr = make_r(OP_SUB, rd, rd, rd);
            ST_MOV:  instr = make_i(OP_MOV, rd, '0);
            ST_ADD:  instr = make_r(OP_ADD, rd, rd, rs1);
            default: instr = NOP_INSTR;
        endcase
    end

endmodule

// File: rtl/ucode_issue_ctrl.sv
// Passes IF->ID instructions through; expands MUL Rd,Rs,#imm into MOV + imm x ADD (or one SUB).
// Latency: pass-through 0 cycles; first micro-op the cycle after MUL acceptance.
// Backpressure: in_ready follows out_ready when idle, low while sequencing. UCODE_PERF_EN adds uop_count.
module ucode_issue_ctrl
    import ucode_pkg::*;
#(
    parameter logic [6:0] MUL_OPCODE = OP_MUL,
    parameter int         CNT_W      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_instr,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_instr,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        flush,
    output logic        busy,
    output logic        err
`ifdef UCODE_PERF_EN
    ,
    output logic [31:0] uop_count
`endif
);

    state_e             state_q, state_d;
    logic [3:0]         rd_q, rd_d;
    logic [3:0]         rs1_q, rs1_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               is_mul;
    logic               mul_acc;
    logic [CNT_W-1:0]   in_imm;
    logic [31:0]        uop_instr;

    assign is_mul = (in_instr[OPC_LSB +: OPC_W] == MUL_OPCODE);
    assign in_imm = in_instr[CNT_W-1:0];

    ucode_uop_gen u_uop_gen (
        .state (state_q),
        .rd    (rd_q),
        .rs1   (rs1_q),
        .instr (uop_instr)
    );

    // Flush masks both handshakes in the same cycle it is asserted.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_instr = uop_instr;
        if (!flush) begin
            if (state_q == ST_IDLE) begin
                in_ready  = out_ready;
                out_valid = in_valid && !is_mul;
                out_instr = in_instr;
            end else begin
                out_valid = 1'b1;
            end
        end
    end

    assign mul_acc = in_valid && in_ready && is_mul;
    assign busy    = (state_q != ST_IDLE);
    assign err     = err_q;

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
            rd_d    = '0;
            rs1_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mul_acc) begin
                        rd_d  = in_instr[RD_LSB +: REG_W];
                        rs1_d = in_instr[RS1_LSB +: REG_W];
                        if (in_imm == '0) begin
                            state_d = ST_CLR;
                        end else if (in_instr[RD_LSB +: REG_W] == in_instr[RS1_LSB +: REG_W]) begin
                            err_d = 1'b1;
                        end else begin
                            cnt_d   = in_imm;
                            state_d = ST_MOV;
                        end
                    end
                end
                ST_CLR: if (out_ready) state_d = ST_IDLE;
                ST_MOV: if (out_ready) state_d = ST_ADD;
                ST_ADD: begin
                    if (out_ready) begin
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rd_q    <= '0;
            rs1_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

`ifdef UCODE_PERF_EN
    logic        uop_fire;
    logic [31:0] uop_count_q, uop_count_d;

    assign uop_fire = out_valid && out_ready && (state_q != ST_IDLE);

    // Saturating; flush deliberately does not clear it.
    always_comb begin
        uop_count_d = uop_count_q;
        if (uop_fire && (uop_count_q != '1)) uop_count_d = uop_count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) uop_count_q <= '0;
        else        uop_count_q <= uop_count_d;
    end

    assign uop_count = uop_count_q;
`endif

endmodule

// File: tb/tb_ucode_issue_ctrl.sv
// Self-checking bench for ucode_issue_ctrl: directed scenarios plus a randomized
// stream compared against an instruction-level expansion model.
module tb_ucode_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_instr;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_instr;
    logic        out_valid;
    logic        out_ready;
    logic        flush;
    logic        busy;
    logic        err;
`ifdef UCODE_PERF_EN
    logic [31:0] uop_count;
`endif

    int tests = 0;
    int fails = 0;
    int exp_uops = 0;

    logic [31:0] exp_q[$];
    int          exp_errs;

    ucode_issue_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_instr  (in_instr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_instr (out_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .busy      (busy),
        .err       (err)
`ifdef UCODE_PERF_EN
        ,
        .uop_count (uop_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] enc_mul(input int rd, input int rs, input int imm);
        return {7'b0110011, 4'(rd), 4'(rs), 1'b0, 16'(imm)};
    endfunction
    function automatic logic [31:0] enc_add(input int rd, input int a, input int b);
        return {7'b0110001, 4'(rd), 4'(a), 4'(b), 13'b0};
    endfunction
    function automatic logic [31:0] enc_sub(input int rd, input int a, input int b);
        return {7'b0110010, 4'(rd), 4'(a), 4'(b), 13'b0};
    endfunction
    function automatic logic [31:0] enc_mov(input int rd, input int imm);
        return {7'b0000000, 4'(rd), 5'b0, 16'(imm)};
    endfunction

    // Instruction-level model: what ID must see for one accepted IF instruction.
    task automatic model_expand(input logic [31:0] ins);
        int rd, rs, imm;
        if (ins[31:25] != 7'b0110011) begin
            exp_q.push_back(ins);
            return;
        end
        rd  = int'(ins[24:21]);
        rs  = int'(ins[20:17]);
        imm = int'(ins[15:0]);
        if (imm == 0) begin
            exp_q.push_back(enc_sub(rd, rd, rd));
            exp_uops += 1;
        end else if (rd == rs) begin
            exp_errs += 1;
        end else begin
            exp_q.push_back(enc_mov(rd, 0));
            for (int k = 0; k < imm; k++) exp_q.push_back(enc_add(rd, rd, rs));
            exp_uops += imm + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_perf(input string name);
`ifdef UCODE_PERF_EN
        tests++;
        if (uop_count !== 32'(exp_uops)) begin
            fails++;
            $display("FAIL %s uop_count: got %0d expected %0d", name, uop_count, exp_uops);
        end
`else
        if (name.len() < 0) $display("%s", name);
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_instr = '0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        exp_uops = 0;
        tick(); tick();
        #2;
        tests++;
        if (busy !== 1'b0 || err !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset: busy=%b err=%b out_valid=%b in_ready=%b expected 0 0 0 1",
                     busy, err, out_valid, in_ready);
        end
        check_perf("reset");
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_passthrough();
        logic [31:0] a;
        a = enc_add(2, 3, 4);
        in_instr = a; in_valid = 1'b1; out_ready = 1'b1;
        #2;
        tests++;
        if (out_valid !== 1'b1 || out_instr !== a || busy !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL passthrough: v=%b instr=%h busy=%b rdy=%b expected 1 %h 0 1",
                     out_valid, out_instr, busy, in_ready, a);
        end
        tick();
        in_instr = enc_mul(1, 0, 3); out_ready = 1'b0;
        #2;
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL mul_blocked: in_ready=%b out_valid=%b expected 0 0", in_ready, out_valid);
        end
        tick();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL mul_blocked_busy: got %b expected 0", busy);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
    endtask

    task automatic test_mul_expand();
        logic [31:0] exp[4];
        exp[0] = enc_mov(1, 0);
        for (int i = 1; i < 4; i++) exp[i] = enc_add(1, 1, 0);
        in_instr = enc_mul(1, 0, 3); in_valid = 1'b1; out_ready = 1'b1;
        #2;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL mul_accept: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        tick();
        in_valid = 1'b0; in_instr = '0;
        for (int i = 0; i < 4; i++) begin
            #2;
            tests++;
            if (out_valid !== 1'b1 || out_instr !== exp[i] || in_ready !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL mul3_uop%0d: v=%b instr=%h rdy=%b busy=%b expected 1 %h 0 1",
                         i, out_valid, out_instr, in_ready, busy, exp[i]);
            end
            tick();
        end
        #2;
        tests++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL mul3_done: busy=%b in_ready=%b expected 0 1", busy, in_ready);
        end
        exp_uops += 4;
        check_perf("mul3");
        tick();
    endtask

    task automatic test_clr_err();
        in_instr = enc_mul(5, 2, 0); in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        #2;
        tests++;
        if (out_valid !== 1'b1 || out_instr !== enc_sub(5, 5, 5)) begin
            fails++;
            $display("FAIL clr: v=%b instr=%h expected 1 %h", out_valid, out_instr, enc_sub(5, 5, 5));
        end
        tick();
        #2;
        tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL clr_done: busy=%b v=%b expected 0 0", busy, out_valid);
        end
        exp_uops += 1;
        tick();
        in_instr = enc_mul(1, 1, 2); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #2;
        tests++;
        if (err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL err_pulse: err=%b busy=%b v=%b rdy=%b expected 1 0 0 1",
                     err, busy, out_valid, in_ready);
        end
        tick();
        #2;
        tests++;
        if (err !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL err_clear: err=%b v=%b expected 0 0", err, out_valid);
        end
        check_perf("clr_err");
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] add_w;
        int adds, xfers;
        add_w = enc_add(1, 1, 0);
        adds = 0; xfers = 0;
        in_instr = enc_mul(1, 0, 2); in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        #2;
        if (out_valid && out_ready && busy) xfers++;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            tests++;
            if (out_valid !== 1'b1 || out_instr !== add_w || busy !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold%0d: v=%b instr=%h busy=%b expected 1 %h 1",
                         i, out_valid, out_instr, busy, add_w);
            end
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #2;
            if (out_valid && busy) begin
                xfers++;
                if (out_instr === add_w) adds++;
            end
            tick();
        end
        tests++;
        if (adds != 2 || xfers != 3) begin
            fails++;
            $display("FAIL bp_count: adds=%0d xfers=%0d expected 2 3", adds, xfers);
        end
        exp_uops += 3;
        check_perf("backpressure");
    endtask

    task automatic test_flush();
        logic [31:0] p;
        p = enc_sub(7, 8, 9);
        in_instr = enc_mul(3, 1, 5); in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        flush = 1'b1; in_instr = p; in_valid = 1'b1;
        #2;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL flush_cycle: v=%b rdy=%b expected 0 0", out_valid, in_ready);
        end
        tick();
        flush = 1'b0;
        #2;
        tests++;
        if (busy !== 1'b0 || out_valid !== 1'b1 || out_instr !== p || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_after: busy=%b v=%b instr=%h rdy=%b expected 0 1 %h 1",
                     busy, out_valid, out_instr, in_ready, p);
        end
        exp_uops += 2;
        check_perf("flush");
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] e0, e1;
        in_instr = enc_mul(2, 4, 3); in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid: busy=%b v=%b rdy=%b expected 0 0 1", busy, out_valid, in_ready);
        end
        exp_uops = 0;
        check_perf("rst_mid");
        tick();
        rst_n = 1'b1;
        tick();
        e0 = enc_mov(6, 0);
        e1 = enc_add(6, 6, 7);
        in_instr = enc_mul(6, 7, 1); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #2;
        tests++;
        if (out_valid !== 1'b1 || out_instr !== e0) begin
            fails++;
            $display("FAIL rst_mov: v=%b instr=%h expected 1 %h", out_valid, out_instr, e0);
        end
        tick();
        #2;
        tests++;
        if (out_valid !== 1'b1 || out_instr !== e1) begin
            fails++;
            $display("FAIL rst_add: v=%b instr=%h expected 1 %h", out_valid, out_instr, e1);
        end
        tick();
        #2;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_done: busy=%b expected 0", busy);
        end
        exp_uops += 2;
        check_perf("rst_reissue");
        tick();
    endtask

    task automatic test_random();
        logic [31:0] prog[$];
        logic [31:0] r, prev_instr, got;
        logic        prev_stall;
        int idx, cyc, errs_seen, n;
        n = 60;
        exp_q.delete();
        exp_errs = 0;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) < 4) begin
                int rd, rs;
                rd = int'($urandom_range(0, 15));
                rs = ($urandom_range(0, 3) == 0) ? rd : int'($urandom_range(0, 15));
                r = enc_mul(rd, rs, int'($urandom_range(0, 4)));
            end else begin
                r = $urandom;
                if (r[31:25] == 7'b0110011) r[31] = 1'b1;
            end
            prog.push_back(r);
            model_expand(r);
        end
        idx = 0; cyc = 0; errs_seen = 0; prev_stall = 1'b0; prev_instr = '0;
        while ((idx < n || busy) && cyc < 3000) begin
            in_valid  = (idx < n) && ($urandom_range(0, 3) != 0);
            in_instr  = (idx < n) ? prog[idx] : 32'h0;
            out_ready = ($urandom_range(0, 3) != 0);
            #2;
            if (err === 1'b1) errs_seen++;
            if (prev_stall) begin
                tests++;
                if (out_valid !== 1'b1 || out_instr !== prev_instr) begin
                    fails++;
                    $display("FAIL rnd_hold: v=%b instr=%h expected 1 %h", out_valid, out_instr, prev_instr);
                end
            end
            if (busy === 1'b1 && in_ready !== 1'b0) begin
                tests++;
                fails++;
                $display("FAIL rnd_in_ready_busy: got %b expected 0", in_ready);
            end
            if (out_valid === 1'b1 && out_ready) begin
                tests++;
                got = out_instr;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL rnd_extra: got %h expected nothing", got);
                end else begin
                    r = exp_q.pop_front();
                    if (got !== r) begin
                        fails++;
                        $display("FAIL rnd_stream: got %h expected %h", got, r);
                    end
                end
            end
            prev_stall = (busy === 1'b1) && (out_valid === 1'b1) && !out_ready;
            prev_instr = out_instr;
            if (in_valid && in_ready === 1'b1) idx++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #2;
            if (err === 1'b1) errs_seen++;
            tick();
        end
        tests++;
        if (cyc >= 3000 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL rnd_drain: cycles=%0d leftover=%0d expected <3000 0", cyc, exp_q.size());
        end
        tests++;
        if (errs_seen != exp_errs) begin
            fails++;
            $display("FAIL rnd_err: got %0d expected %0d", errs_seen, exp_errs);
        end
        check_perf("random");
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_mul_expand();
        test_clr_err();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
